// File: rtl/pipe_perf_counter.sv
// pipe_perf_counter: cycle + per-channel event counters, run/freeze/done FSM,
// atomic shadow snapshots. Define PERF_SAT_EN for saturating counters.
module pipe_perf_counter #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int SEL_W       = $clog2(NUM_CH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              freeze_i,
  input  logic              clear_i,
  input  logic [NUM_CH-1:0] event_i,
  input  logic              snap_i,
  input  logic [SEL_W-1:0]  rd_sel_i,
  output logic [CNT_W-1:0]  rd_data_o,
  output logic [CNT_W-1:0]  cycle_o,
  output logic [NUM_CH:0]   ovf_o,
  output logic [1:0]        state_o,
  output logic              done_o
);

  localparam int NC = NUM_CH + 1;
  localparam logic [CNT_W:0] LIM = (CNT_W+1)'(CYCLE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_RUN    = 2'b01,
    S_FROZEN = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  state_t state_q, state_d;

  // slot NUM_CH is the cycle counter, slots below are event channels
  logic [CNT_W-1:0] cnt_q [NC];
  logic [CNT_W-1:0] cnt_d [NC];
  logic [CNT_W-1:0] shd_q [NC];
  logic [NC-1:0]    hit;
  logic [NC-1:0]    ovf_q;
  logic [NC-1:0]    ovf_set;
  logic [CNT_W-1:0] rd_mux;
  logic             run;
  logic             lim_hit;

  assign run = (state_q == S_RUN);
  assign hit = {1'b1, event_i};

  assign lim_hit = (CYCLE_LIMIT != 0) && run &&
    (({1'b0, cnt_q[NUM_CH]} + (CNT_W+1)'(1)) == LIM);

  always_comb begin
    ovf_set = '0;
    for (int k = 0; k < NC; k++) begin
      cnt_d[k] = cnt_q[k];
      if (run && hit[k]) begin
        ovf_set[k] = &cnt_q[k];
`ifdef PERF_SAT_EN
        if (!(&cnt_q[k]))
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
`else
        cnt_d[k] = cnt_q[k] + CNT_W'(1);
`endif
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = S_IDLE;
    end else if (lim_hit) begin
      state_d = S_DONE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i && !freeze_i)
            state_d = S_RUN;
        end
        S_RUN: begin
          if (!start_i)
            state_d = S_IDLE;
          else if (freeze_i)
            state_d = S_FROZEN;
        end
        S_FROZEN: begin
          if (!start_i)
            state_d = S_IDLE;
          else if (!freeze_i)
            state_d = S_RUN;
        end
        S_DONE: state_d = S_DONE;
      endcase
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NC; k++) begin
      if (rd_sel_i == SEL_W'(k))
        rd_mux = shd_q[k];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NC; k++) begin
        cnt_q[k] <= '0;
        shd_q[k] <= '0;
      end
      ovf_q <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NC; k++) begin
        cnt_q[k] <= '0;
        shd_q[k] <= '0;
      end
      ovf_q <= '0;
    end else begin
      // shadows take pre-increment values, all on one edge
      for (int k = 0; k < NC; k++) begin
        cnt_q[k] <= cnt_d[k];
        if (snap_i)
          shd_q[k] <= cnt_q[k];
      end
      ovf_q <= ovf_q | ovf_set;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)
      rd_data_o <= '0;
    else
      rd_data_o <= rd_mux;
  end

  assign cycle_o = cnt_q[NUM_CH];
  assign ovf_o   = ovf_q;
  assign state_o = state_q;
  assign done_o  = (state_q == S_DONE);

endmodule

// File: tb/tb_pipe_perf_counter.sv
// tb_pipe_perf_counter: directed vectors, expectations queued to a
// scoreboard and compared by a negedge monitor.
module tb_pipe_perf_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, freeze, clear, snap;
  logic [3:0]  ev;
  logic [2:0]  sel;
  logic [31:0] rd, cyc;
  logic [4:0]  ovf;
  logic [1:0]  st;
  logic        done;

  logic        b_start, b_freeze, b_clear, b_snap;
  logic [3:0]  b_ev;
  logic [2:0]  b_sel;
  logic [3:0]  b_rd, b_cyc;
  logic [4:0]  b_ovf;
  logic [1:0]  b_st;
  logic        b_done;

  pipe_perf_counter #(
    .NUM_CH(4), .CNT_W(32), .CYCLE_LIMIT(30)
  ) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .freeze_i(freeze), .clear_i(clear), .event_i(ev),
    .snap_i(snap), .rd_sel_i(sel), .rd_data_o(rd),
    .cycle_o(cyc), .ovf_o(ovf), .state_o(st), .done_o(done)
  );

  pipe_perf_counter #(
    .NUM_CH(4), .CNT_W(4), .CYCLE_LIMIT(0)
  ) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(b_start),
    .freeze_i(b_freeze), .clear_i(b_clear), .event_i(b_ev),
    .snap_i(b_snap), .rd_sel_i(b_sel), .rd_data_o(b_rd),
    .cycle_o(b_cyc), .ovf_o(b_ovf), .state_o(b_st), .done_o(b_done)
  );

  typedef enum {
    K_ST, K_DONE, K_CYC, K_OVF, K_RD,
    K_BRD, K_BOVF, K_BCYC, K_BST
  } kind_t;

  typedef struct {
    kind_t       kind;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef PERF_SAT_EN
  localparam logic [3:0] B_CH2   = 4'd15;
  localparam logic [3:0] B_CSHD  = 4'd15;
  localparam logic [3:0] B_CLIVE = 4'd15;
`else
  localparam logic [3:0] B_CH2   = 4'd1;
  localparam logic [3:0] B_CSHD  = 4'd1;
  localparam logic [3:0] B_CLIVE = 4'd2;
`endif

  task automatic push_exp(input kind_t k, input logic [63:0] v,
                          input string nm);
    exp_t e;
    e.kind = k;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = sb.pop_front();
      case (e.kind)
        K_ST:    act = 64'(st);
        K_DONE:  act = 64'(done);
        K_CYC:   act = 64'(cyc);
        K_OVF:   act = 64'(ovf);
        K_RD:    act = 64'(rd);
        K_BRD:   act = 64'(b_rd);
        K_BOVF:  act = 64'(b_ovf);
        K_BCYC:  act = 64'(b_cyc);
        default: act = 64'({b_done, b_st});
      endcase
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got 0x%0h want 0x%0h", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    start = 0; freeze = 0; clear = 0; snap = 0; ev = '0; sel = '0;
    b_start = 0; b_freeze = 0; b_clear = 0; b_snap = 0;
    b_ev = '0; b_sel = '0;
    tickn(2);
    rst_n = 1'b1;
    push_exp(K_ST, 0, "rst_state");
    push_exp(K_DONE, 0, "rst_done");
    push_exp(K_CYC, 0, "rst_cycle");
    push_exp(K_OVF, 0, "rst_ovf");
    push_exp(K_RD, 0, "rst_rd");
    tick();

    // cycle limit
    start = 1; ev = 4'b0001;
    tickn(31);
    push_exp(K_ST, 3, "lim_state");
    push_exp(K_DONE, 1, "lim_done");
    push_exp(K_CYC, 30, "lim_cycle");
    tickn(10);
    push_exp(K_CYC, 30, "done_cycle_hold");
    start = 0; ev = '0;
    tick();
    push_exp(K_ST, 3, "done_ignores_start");
    snap = 1; tick(); snap = 0;
    sel = 0; tick(); push_exp(K_RD, 30, "lim_ch0");
    sel = 1; tick(); push_exp(K_RD, 0, "lim_ch1");
    sel = 4; tick(); push_exp(K_RD, 30, "lim_cyc_shd");
    sel = 5; tick(); push_exp(K_RD, 0, "sel_oob");

    // freeze inside a run
    clear = 1; tick(); clear = 0;
    push_exp(K_ST, 0, "clr_state");
    push_exp(K_DONE, 0, "clr_done");
    push_exp(K_CYC, 0, "clr_cycle");
    start = 1; ev = 4'b0010;
    tick();
    tickn(7);
    freeze = 1;
    tickn(2);
    push_exp(K_ST, 2, "frz_state");
    push_exp(K_CYC, 8, "frz_cycle");
    tickn(3);
    freeze = 0;
    tickn(8);
    push_exp(K_CYC, 15, "frz_total");
    snap = 1; start = 0;
    tick();
    snap = 0;
    push_exp(K_ST, 0, "stop_idle");
    push_exp(K_CYC, 16, "stop_cycle");
    sel = 1; tick(); push_exp(K_RD, 15, "frz_ch1");
    sel = 4; tick(); push_exp(K_RD, 15, "frz_cyc_shd");
    sel = 0; tick(); push_exp(K_RD, 0, "frz_ch0");

    // snapshot takes pre-increment value
    clear = 1; tick(); clear = 0;
    start = 1; ev = 4'b0001;
    tick();
    tickn(7);
    snap = 1; sel = 0;
    tick();
    snap = 0; ev = '0; freeze = 1;
    tick();
    push_exp(K_RD, 7, "snap_pre_inc");
    push_exp(K_CYC, 9, "snap_cycle");
    push_exp(K_ST, 2, "snap_frozen");
    snap = 1; tick(); snap = 0;
    tick();
    push_exp(K_RD, 8, "live_ch0");

    // clear beats events and snap
    freeze = 0;
    tick();
    push_exp(K_ST, 1, "resume_run");
    clear = 1; ev = 4'hf; snap = 1; start = 0;
    tick();
    clear = 0; ev = '0; snap = 0;
    push_exp(K_ST, 0, "clr_all_state");
    push_exp(K_CYC, 0, "clr_all_cycle");
    push_exp(K_OVF, 0, "clr_all_ovf");
    sel = 0; tick(); push_exp(K_RD, 0, "clr_shd_ch0");
    sel = 4; tick(); push_exp(K_RD, 0, "clr_shd_cyc");

    // async reset mid-run
    start = 1; ev = 4'hf;
    tick();
    tickn(5);
    snap = 1; tick(); snap = 0;
    tickn(2);
    push_exp(K_CYC, 8, "pre_rst_cycle");
    tick();
    rst_n = 1'b0;
    #1;
    push_exp(K_ST, 0, "arst_state");
    push_exp(K_CYC, 0, "arst_cycle");
    push_exp(K_OVF, 0, "arst_ovf");
    push_exp(K_DONE, 0, "arst_done");
    push_exp(K_RD, 0, "arst_rd");
    tick();
    start = 0; ev = '0;
    rst_n = 1'b1;
    sel = 2; tick(); push_exp(K_RD, 0, "arst_shd");

    // narrow counters: wrap or saturate
    b_start = 1; b_ev = 4'b0100;
    tick();
    push_exp(K_BST, 3'b001, "b_run");
    tickn(15);
    push_exp(K_BOVF, 0, "b_ovf_at_max");
    push_exp(K_BCYC, 15, "b_cyc_at_max");
    tickn(2);
    push_exp(K_BOVF, 5'b10100, "b_ovf_set");
    b_start = 0; b_ev = '0; b_snap = 1; b_sel = 2;
    tick();
    b_snap = 0;
    tick();
    push_exp(K_BRD, 64'(B_CH2), "b_ch2");
    b_sel = 4;
    tick();
    push_exp(K_BRD, 64'(B_CSHD), "b_cyc_shd");
    push_exp(K_BCYC, 64'(B_CLIVE), "b_cyc_live");
    push_exp(K_BOVF, 5'b10100, "b_ovf_sticky");

    tick();
    tick();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
